// File: rtl/pixie_pkg.sv
// ----------------------------------------------------------------------------
// pixie_pkg
// Shared definitions for the Pixie-style display front end:
//   - CPU state code encodings (SC bus)
//   - line repeat encodings (scan lines per stored row)
//   - helpers for stored-row count and inclusive range tests
// ----------------------------------------------------------------------------
package pixie_pkg;

    typedef enum logic [1:0] {
        SC_FETCH   = 2'b00,
        SC_EXECUTE = 2'b01,
        SC_DMA     = 2'b10,
        SC_INT     = 2'b11
    } sc_e;

    typedef enum logic [1:0] {
        REP_1 = 2'd0,
        REP_2 = 2'd1,
        REP_4 = 2'd2,
        REP_8 = 2'd3
    } rep_e;

    // Number of distinct stored rows in the active window for a repeat mode.
    function automatic int rows_for_repeat(input int activeLines, input rep_e rep);
        return activeLines >> rep;
    endfunction

    // Inclusive range test used by the window decodes.
    function automatic logic in_range(input int x, input int lo, input int hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/pixie_timing_gen.sv
// ----------------------------------------------------------------------------
// pixie_timing_gen
// Horizontal (machine-cycle slot) and vertical (scan line) counters for the
// display front end, plus the window decodes the top level registers.
//
// Decodes named o_next_* look at the counter values the next clk_enable tick
// will produce, so the top level can register them on that tick and have its
// outputs reflect the post-tick position. o_line_wrap and o_cur_active describe
// the current (pre-tick) position, which is where a DMA cycle issued in this
// tick belongs.
//
// Ports:
//   i_clk, i_reset_n, i_clk_enable : clock, async active-low reset, tick
//   o_line_wrap         : current slot is the last one of the line
//   o_cur_active        : current line is inside the active window
//   o_next_frame_start  : this tick wraps the counters to (0, 0)
//   o_next_active_start : this tick enters the first active line
//   o_next_active       : post-tick line is inside the active window
//   o_next_int_win      : post-tick line is inside the interrupt lead window
//   o_next_ef_win       : post-tick line is inside either EF window
//   o_next_dma_slot     : post-tick slot is one of the DMA slots
// ----------------------------------------------------------------------------
module pixie_timing_gen
    import pixie_pkg::*;
#(
    parameter int BYTES_PER_LINE  = 14,
    parameter int LINES_PER_FRAME = 262,
    parameter int ACTIVE_START    = 80,
    parameter int ACTIVE_LINES    = 128,
    parameter int DMA_START       = 1,
    parameter int DMA_BYTES       = 8,
    parameter int INT_LEAD        = 2,
    parameter int EF_LINES        = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clk_enable,
    output logic o_line_wrap,
    output logic o_cur_active,
    output logic o_next_frame_start,
    output logic o_next_active_start,
    output logic o_next_active,
    output logic o_next_int_win,
    output logic o_next_ef_win,
    output logic o_next_dma_slot
);

    localparam int H_W        = $clog2(BYTES_PER_LINE);
    localparam int V_W        = $clog2(LINES_PER_FRAME);
    localparam int ACTIVE_END = ACTIVE_START + ACTIVE_LINES - 1;

    logic [H_W-1:0] r_h;
    logic [V_W-1:0] r_v;
    logic [H_W-1:0] w_h_next;
    logic [V_W-1:0] w_v_next;
    logic           w_frame_wrap;

    // Next-position arithmetic: h wraps every line, v steps on the h wrap and
    // wraps at the end of the frame.
    assign o_line_wrap  = (r_h == H_W'(BYTES_PER_LINE - 1));
    assign w_frame_wrap = o_line_wrap && (r_v == V_W'(LINES_PER_FRAME - 1));
    assign w_h_next     = o_line_wrap ? '0 : r_h + 1'b1;
    assign w_v_next     = w_frame_wrap ? '0 : (o_line_wrap ? r_v + 1'b1 : r_v);

    // Window decodes: the active test on the current line qualifies DMA
    // capture, everything else is taken from the post-tick position.
    assign o_cur_active        = in_range(int'(r_v), ACTIVE_START, ACTIVE_END);
    assign o_next_frame_start  = w_frame_wrap;
    assign o_next_active_start = o_line_wrap && (int'(w_v_next) == ACTIVE_START);
    assign o_next_active       = in_range(int'(w_v_next), ACTIVE_START, ACTIVE_END);
    assign o_next_int_win      = in_range(int'(w_v_next), ACTIVE_START - INT_LEAD,
                                          ACTIVE_START - 1);
    assign o_next_ef_win       = in_range(int'(w_v_next), ACTIVE_START - EF_LINES,
                                          ACTIVE_START - 1)
                              || in_range(int'(w_v_next), ACTIVE_END + 1 - EF_LINES,
                                          ACTIVE_END);
    assign o_next_dma_slot     = in_range(int'(w_h_next), DMA_START,
                                          DMA_START + DMA_BYTES - 1);

    // Counter registers only move on machine-cycle ticks.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_clk_enable) begin
            r_h <= w_h_next;
            r_v <= w_v_next;
        end
    end

endmodule

// File: rtl/pixie_dp_front_end_gen.sv
// ----------------------------------------------------------------------------
// pixie_dp_front_end_gen
// Parametrised Pixie-style display front end for a CDP1802 core. Generates
// frame/line timing, DMA-out requests, interrupt and EF flag, and writes DMA
// bytes into the display frame buffer with selectable line repeat.
//
// Ports:
//   clk, reset_n, clk_enable : clock, async active-low reset, machine tick
//   SC          : CPU state code (10 = DMA cycle)
//   disp_on     : display enable strobe
//   disp_off    : display disable strobe (wins over disp_on)
//   line_repeat : scan lines per stored row (1/2/4/8), latched per frame
//   data_in     : CPU data bus, captured on accepted DMA cycles
//   DMAO_n      : DMA-out request, active low
//   INT_n       : interrupt request, active low
//   EF_n        : frame flag, active low
//   mem_addr, mem_data, mem_wr_en : frame buffer write port
//   frame_start : one-clk pulse when the counters wrap to (0, 0)
//   dma_overrun : one-clk pulse on a DMA cycle beyond the per-line limit
// ----------------------------------------------------------------------------
module pixie_dp_front_end_gen
    import pixie_pkg::*;
#(
    parameter int BYTES_PER_LINE  = 14,
    parameter int LINES_PER_FRAME = 262,
    parameter int ACTIVE_START    = 80,
    parameter int ACTIVE_LINES    = 128,
    parameter int DMA_START       = 1,
    parameter int DMA_BYTES       = 8,
    parameter int INT_LEAD        = 2,
    parameter int EF_LINES        = 4,
    parameter int ADDR_W          = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_enable,
    input  logic [1:0]        SC,
    input  logic              disp_on,
    input  logic              disp_off,
    input  logic [1:0]        line_repeat,
    input  logic [7:0]        data_in,
    output logic              DMAO_n,
    output logic              INT_n,
    output logic              EF_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr_en,
    output logic              frame_start,
    output logic              dma_overrun
);

    localparam int BC_W  = $clog2(DMA_BYTES + 1);
    localparam int ROW_W = $clog2(ACTIVE_LINES);

    logic             w_line_wrap;
    logic             w_cur_active;
    logic             w_next_frame_start;
    logic             w_next_active_start;
    logic             w_next_active;
    logic             w_next_int_win;
    logic             w_next_ef_win;
    logic             w_next_dma_slot;

    logic             r_enabled;
    rep_e             r_rep;
    logic [BC_W-1:0]  r_byte_cnt;
    logic [ROW_W-1:0] r_row_cnt;
    logic [2:0]       r_rep_cnt;

    logic              w_en_next;
    logic              w_dma_cycle;
    logic              w_byte_ok;
    logic              w_last_rep;
    logic              w_last_row;
    logic [ADDR_W-1:0] w_addr;

    pixie_timing_gen #(
        .BYTES_PER_LINE  (BYTES_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .ACTIVE_START    (ACTIVE_START),
        .ACTIVE_LINES    (ACTIVE_LINES),
        .DMA_START       (DMA_START),
        .DMA_BYTES       (DMA_BYTES),
        .INT_LEAD        (INT_LEAD),
        .EF_LINES        (EF_LINES)
    ) u_timing (
        .i_clk               (clk),
        .i_reset_n           (reset_n),
        .i_clk_enable        (clk_enable),
        .o_line_wrap         (w_line_wrap),
        .o_cur_active        (w_cur_active),
        .o_next_frame_start  (w_next_frame_start),
        .o_next_active_start (w_next_active_start),
        .o_next_active       (w_next_active),
        .o_next_int_win      (w_next_int_win),
        .o_next_ef_win       (w_next_ef_win),
        .o_next_dma_slot     (w_next_dma_slot)
    );

    // The request outputs follow the enable value this tick produces, while
    // DMA acceptance uses the enable value in force when the CPU issued the
    // cycle. The row limit keeps the address inside the active frame buffer
    // area even after the last active line wraps.
    assign w_en_next   = disp_off ? 1'b0 : (disp_on ? 1'b1 : r_enabled);
    assign w_dma_cycle = (SC == SC_DMA) && r_enabled && w_cur_active;
    assign w_byte_ok   = (r_byte_cnt < BC_W'(DMA_BYTES));
    assign w_last_rep  = (r_rep_cnt == 3'((1 << r_rep) - 1));
    assign w_last_row  = (r_row_cnt == ROW_W'(rows_for_repeat(ACTIVE_LINES, r_rep) - 1));
    assign w_addr      = ADDR_W'(int'(r_row_cnt) * DMA_BYTES + int'(r_byte_cnt));

    // Enable flag, registered output decodes, DMA capture and row tracking.
    // Pulse outputs drop back to zero on every clk so they are one clk wide
    // even when ticks arrive back to back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enabled   <= 1'b0;
            r_rep       <= REP_1;
            r_byte_cnt  <= '0;
            r_row_cnt   <= '0;
            r_rep_cnt   <= '0;
            DMAO_n      <= 1'b1;
            INT_n       <= 1'b1;
            EF_n        <= 1'b1;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_wr_en   <= 1'b0;
            frame_start <= 1'b0;
            dma_overrun <= 1'b0;
        end else begin
            mem_wr_en   <= 1'b0;
            frame_start <= 1'b0;
            dma_overrun <= 1'b0;
            if (clk_enable) begin
                r_enabled   <= w_en_next;
                DMAO_n      <= ~(w_en_next & w_next_active & w_next_dma_slot);
                INT_n       <= ~(w_en_next & w_next_int_win);
                EF_n        <= ~w_next_ef_win;
                frame_start <= w_next_frame_start;
                if (w_next_frame_start) begin
                    r_rep <= rep_e'(line_repeat);
                end
                if (w_dma_cycle) begin
                    if (w_byte_ok) begin
                        mem_addr   <= w_addr;
                        mem_data   <= data_in;
                        mem_wr_en  <= 1'b1;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end else begin
                        dma_overrun <= 1'b1;
                    end
                end
                if (w_line_wrap) begin
                    r_byte_cnt <= '0;
                    if (w_next_active_start) begin
                        r_row_cnt <= '0;
                        r_rep_cnt <= '0;
                    end else if (w_cur_active) begin
                        if (w_last_rep) begin
                            r_rep_cnt <= '0;
                            r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixie_dp_front_end_gen.sv
// ----------------------------------------------------------------------------
// tb_pixie_dp_front_end_gen
// Self-checking bench for pixie_dp_front_end_gen. A frame-position model
// predicts every output on every clk; per-frame statistics gathered from the
// DUT are compared with hand-computed totals.
// ----------------------------------------------------------------------------
module tb_pixie_dp_front_end_gen;

    localparam int BPL   = 14;
    localparam int LPF   = 262;
    localparam int AS    = 80;
    localparam int AL    = 128;
    localparam int DS    = 1;
    localparam int DB    = 8;
    localparam int IL    = 2;
    localparam int EFL   = 4;
    localparam int AW    = 10;
    localparam int FRAME = BPL * LPF;
    localparam int NONE  = -1;

    logic          clk;
    logic          reset_n;
    logic          clk_enable;
    logic [1:0]    SC;
    logic          disp_on;
    logic          disp_off;
    logic [1:0]    line_repeat;
    logic [7:0]    data_in;
    logic          DMAO_n;
    logic          INT_n;
    logic          EF_n;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wr_en;
    logic          frame_start;
    logic          dma_overrun;

    int total;
    int bad;
    bit chkOn;

    int            mPos;
    int            mLineCnt;
    bit            mEn;
    int            mRep;
    bit            ticked;
    logic          expDmao, expInt, expEf, expFs, expWr, expOvr;
    logic [AW-1:0] expAddr;
    logic [7:0]    expData;

    int fsCnt, intLow, efLow, dmaoLow, wrCnt, ovrCnt, firstAddr, lastAddr, addr0Cnt;

    pixie_dp_front_end_gen #(
        .BYTES_PER_LINE  (BPL),
        .LINES_PER_FRAME (LPF),
        .ACTIVE_START    (AS),
        .ACTIVE_LINES    (AL),
        .DMA_START       (DS),
        .DMA_BYTES       (DB),
        .INT_LEAD        (IL),
        .EF_LINES        (EFL),
        .ADDR_W          (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_enable  (clk_enable),
        .SC          (SC),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .line_repeat (line_repeat),
        .data_in     (data_in),
        .DMAO_n      (DMAO_n),
        .INT_n       (INT_n),
        .EF_n        (EF_n),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en),
        .frame_start (frame_start),
        .dma_overrun (dma_overrun)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] randSc();
        logic [1:0] s;
        s = 2'($urandom_range(0, 2));
        if (s == 2'b10) s = 2'b11;
        return s;
    endfunction

    // Frame-position model: the whole display state is the tick position in
    // the frame, the enable flag, the repeat latched at the last frame start
    // and the number of bytes already stored on the current line.
    task automatic modelStep();
        int preV;
        int v;
        int h;
        if (!reset_n) begin
            mPos = 0; mLineCnt = 0; mEn = 0; mRep = 0; ticked = 0;
            expDmao = 1; expInt = 1; expEf = 1; expFs = 0; expWr = 0; expOvr = 0;
            expAddr = '0; expData = '0;
            return;
        end
        ticked = clk_enable;
        expWr = 0; expFs = 0; expOvr = 0;
        if (!clk_enable) return;
        preV = mPos / BPL;
        if (SC == 2'b10 && mEn && preV >= AS && preV < AS + AL) begin
            if (mLineCnt < DB) begin
                expWr   = 1;
                expAddr = AW'(((preV - AS) >> mRep) * DB + mLineCnt);
                expData = data_in;
                mLineCnt++;
            end else begin
                expOvr = 1;
            end
        end
        mPos = (mPos + 1) % FRAME;
        if (mPos % BPL == 0) mLineCnt = 0;
        if (disp_off) mEn = 0;
        else if (disp_on) mEn = 1;
        if (mPos == 0) begin
            expFs = 1;
            mRep  = int'(line_repeat);
        end
        v = mPos / BPL;
        h = mPos % BPL;
        expEf   = !((v >= AS - EFL && v < AS) || (v >= AS + AL - EFL && v < AS + AL));
        expInt  = !(mEn && v >= AS - IL && v < AS);
        expDmao = !(mEn && v >= AS && v < AS + AL && h >= DS && h < DS + DB);
    endtask

    // Model advances on every clk edge and on the reset edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            modelStep();
        end
    end

    // Compare process: every output against the model on every falling edge,
    // and per-tick statistics for the literal frame totals.
    initial begin
        forever begin
            @(negedge clk);
            if (chkOn) begin
                checkOutput("DMAO_n",      int'(DMAO_n),      int'(expDmao));
                checkOutput("INT_n",       int'(INT_n),       int'(expInt));
                checkOutput("EF_n",        int'(EF_n),        int'(expEf));
                checkOutput("frame_start", int'(frame_start), int'(expFs));
                checkOutput("mem_wr_en",   int'(mem_wr_en),   int'(expWr));
                checkOutput("dma_overrun", int'(dma_overrun), int'(expOvr));
                checkOutput("mem_addr",    int'(mem_addr),    int'(expAddr));
                checkOutput("mem_data",    int'(mem_data),    int'(expData));
                if (ticked) begin
                    fsCnt   += int'(frame_start);
                    intLow  += int'(!INT_n);
                    efLow   += int'(!EF_n);
                    dmaoLow += int'(!DMAO_n);
                    ovrCnt  += int'(dma_overrun);
                    if (mem_wr_en) begin
                        wrCnt++;
                        if (firstAddr < 0) firstAddr = int'(mem_addr);
                        lastAddr = int'(mem_addr);
                        if (mem_addr == '0) addr0Cnt++;
                    end
                end
            end
        end
    end

    task automatic clearStats();
        fsCnt = 0; intLow = 0; efLow = 0; dmaoLow = 0; wrCnt = 0; ovrCnt = 0;
        firstAddr = -1; lastAddr = -1; addr0Cnt = 0;
    endtask

    // One machine tick, preceded by a random number of idle clocks. The CPU
    // answers a low DMAO_n with a DMA cycle; extra forces an unrequested one.
    task automatic applyStimulus(input bit on, input bit off, input bit extra);
        while ($urandom_range(0, 7) == 0) begin
            @(negedge clk); #1;
            clk_enable = 0; disp_on = 0; disp_off = 0;
            SC = randSc(); data_in = 8'($urandom);
        end
        @(negedge clk); #1;
        clk_enable = 1; disp_on = on; disp_off = off;
        SC = (DMAO_n == 1'b0 || extra) ? 2'b10 : randSc();
        data_in = 8'($urandom);
        @(posedge clk); #1;
    endtask

    // One full frame of ticks with optional actions at given pre-tick positions.
    task automatic runFrame(input int onPos, input int offPos, input int bothPos,
                            input int extraPos, input int repPos, input int repVal,
                            input bit rnd);
        bit on, off, extra;
        clearStats();
        for (int t = 0; t < FRAME; t++) begin
            on    = (mPos == onPos) || (mPos == bothPos);
            off   = (mPos == offPos) || (mPos == bothPos);
            extra = (mPos == extraPos);
            if (mPos == repPos) line_repeat = 2'(repVal);
            if (rnd) begin
                if ($urandom_range(0, 15) == 0) extra = 1;
                if ($urandom_range(0, 1999) == 0) off = 1;
                if ($urandom_range(0, 999) == 0) on = 1;
                if ($urandom_range(0, 499) == 0) line_repeat = 2'($urandom_range(0, 3));
            end
            applyStimulus(on, off, extra);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        total = 0; bad = 0; chkOn = 0;
        clearStats();
        reset_n = 1; clk_enable = 0; SC = 2'b00; disp_on = 0; disp_off = 0;
        line_repeat = 2'd1; data_in = 8'h00;
        #1 reset_n = 0;
        #1 chkOn = 1;
        checkOutput("reset_DMAO_n", int'(DMAO_n), 1);
        checkOutput("reset_INT_n",  int'(INT_n), 1);
        checkOutput("reset_EF_n",   int'(EF_n), 1);
        checkOutput("reset_wr_en",  int'(mem_wr_en), 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1;

        $display("[TB] frame 0: repeat 0 from reset, display enabled");
        runFrame(0, NONE, NONE, NONE, NONE, 0, 0);
        checkOutput("f0_frame_start", fsCnt, 1);
        checkOutput("f0_int_low",     intLow, 28);
        checkOutput("f0_ef_low",      efLow, 112);
        checkOutput("f0_dmao_low",    dmaoLow, 1024);
        checkOutput("f0_writes",      wrCnt, 1024);
        checkOutput("f0_first_addr",  firstAddr, 0);
        checkOutput("f0_last_addr",   lastAddr, 1023);
        checkOutput("f0_overruns",    ovrCnt, 0);
        checkOutput("f0_addr0",       addr0Cnt, 1);

        $display("[TB] frame 1: repeat 1");
        runFrame(NONE, NONE, NONE, NONE, 0, 0, 0);
        checkOutput("f1_writes",    wrCnt, 1024);
        checkOutput("f1_last_addr", lastAddr, 511);
        checkOutput("f1_addr0",     addr0Cnt, 2);

        $display("[TB] frame 2: repeat 0, switch to 2 mid-frame");
        runFrame(NONE, NONE, NONE, NONE, 120 * BPL, 2, 0);
        checkOutput("f2_last_addr", lastAddr, 1023);
        checkOutput("f2_addr0",     addr0Cnt, 1);

        $display("[TB] frame 3: repeat 2, ninth DMA on line 90");
        runFrame(NONE, NONE, NONE, 90 * BPL + 9, NONE, 0, 0);
        checkOutput("f3_writes",    wrCnt, 1024);
        checkOutput("f3_overruns",  ovrCnt, 1);
        checkOutput("f3_last_addr", lastAddr, 255);
        checkOutput("f3_addr0",     addr0Cnt, 4);

        $display("[TB] frame 4: disp_off at line 100 h 4, then on+off together");
        runFrame(NONE, 100 * BPL + 4, 150 * BPL, NONE, NONE, 0, 0);
        checkOutput("f4_writes",    wrCnt, 164);
        checkOutput("f4_dmao_low",  dmaoLow, 164);
        checkOutput("f4_int_low",   intLow, 28);
        checkOutput("f4_ef_low",    efLow, 112);

        $display("[TB] frame 5: display stays disabled");
        runFrame(NONE, NONE, NONE, NONE, NONE, 0, 0);
        checkOutput("f5_int_low",     intLow, 0);
        checkOutput("f5_dmao_low",    dmaoLow, 0);
        checkOutput("f5_ef_low",      efLow, 112);
        checkOutput("f5_writes",      wrCnt, 0);
        checkOutput("f5_frame_start", fsCnt, 1);

        $display("[TB] frames 6-7: randomized traffic");
        runFrame(0, NONE, NONE, NONE, NONE, 0, 1);
        runFrame(NONE, NONE, NONE, NONE, NONE, 0, 1);

        $display("[TB] reset pulse at line 150 h 5");
        line_repeat = 2'd0;
        n = 0;
        while (mPos != 150 * BPL + 5 && n < FRAME) begin
            applyStimulus(n == 0, 0, 0);
            n++;
        end
        checkOutput("reach_reset_point", mPos, 150 * BPL + 5);
        checkOutput("pre_rst_DMAO_n", int'(DMAO_n), 0);
        #2 reset_n = 0; clk_enable = 0;
        #1;
        checkOutput("rst_DMAO_n",      int'(DMAO_n), 1);
        checkOutput("rst_INT_n",       int'(INT_n), 1);
        checkOutput("rst_EF_n",        int'(EF_n), 1);
        checkOutput("rst_wr_en",       int'(mem_wr_en), 0);
        checkOutput("rst_mem_addr",    int'(mem_addr), 0);
        checkOutput("rst_mem_data",    int'(mem_data), 0);
        checkOutput("rst_frame_start", int'(frame_start), 0);
        checkOutput("rst_overrun",     int'(dma_overrun), 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1;
        clearStats();
        n = 0;
        do begin
            applyStimulus(n == 0, 0, 0);
            n++;
        end while (!frame_start && n < FRAME + 100);
        checkOutput("ticks_to_frame_start", n, FRAME);
        @(negedge clk); #1;
        checkOutput("post_rst_first_addr", firstAddr, 0);
        checkOutput("post_rst_writes",     wrCnt, 1024);

        chkOn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixie_dp_front_end_gen.md
Name: pixie_dp_front_end_gen

Overview:
Parametrised next-generation Pixie-style display front end for the CDP1802 core. It generates the frame/line timing, active-low DMA-out requests, interrupt and EF flag, and captures DMA bytes into the display frame buffer. It generalises the fixed-geometry front end with:
- configurable geometry;
- runtime line-repeat mode (1/2/4/8 scan lines per stored row);
- per-line DMA byte limiting with overrun reporting;
- frame-boundary status pulses.

Parameters:
- BYTES_PER_LINE, 14: machine cycles per scan line (>= DMA_START+DMA_BYTES+1).
- LINES_PER_FRAME, 262: scan lines per frame.
- ACTIVE_START, 80: first active (DMA) scan line.
- ACTIVE_LINES, 128: number of active scan lines; must be a multiple of 8.
- DMA_START, 1: first horizontal slot with DMAO_n low.
- DMA_BYTES, 8: DMA slots and stored bytes per line.
- INT_LEAD, 2: number of lines before ACTIVE_START during which INT_n is low.
- EF_LINES, 4: length of each EF_n low window, in lines.
- ADDR_W, 10: frame buffer address width; 2^ADDR_W >= ACTIVE_LINES*DMA_BYTES.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- clk_enable, in, 1: one-clk tick per CPU machine cycle.
- SC, in, 2: CPU state code (00 fetch, 01 execute, 10 DMA, 11 interrupt).
- disp_on, in, 1: display enable strobe.
- disp_off, in, 1: display disable strobe.
- line_repeat, in, 2: 0 = 1 line, 1 = 2 lines, 2 = 4 lines, 3 = 8 lines per stored row.
- data_in, in, 8: CPU data bus.
- DMAO_n, out, 1: DMA-out request, active low.
- INT_n, out, 1: interrupt request, active low.
- EF_n, out, 1: frame flag, active low.
- mem_addr, out, ADDR_W: frame buffer write address.
- mem_data, out, 8: frame buffer write data.
- mem_wr_en, out, 1: frame buffer write strobe, one clk wide.
- frame_start, out, 1: one-clk pulse when the counters wrap to line 0, slot 0.
- dma_overrun, out, 1: one-clk pulse on a DMA cycle rejected by the per-line limit.

Behaviour:
Reset and enable
- Reset (async, reset_n low) clears: h, v, byte_cnt, row_cnt, rep_cnt, enabled, mem_wr_en, frame_start, dma_overrun, mem_addr, mem_data.
- Reset sets DMAO_n = INT_n = EF_n = 1 and latched repeat = 0.
- Reset mid-frame takes effect immediately. Timing restarts at h = 0, v = 0 on the first clk_enable after release.
- All state advances only on clk_enable ticks. Outputs are registered and valid the clk after the tick.
- enabled: set by disp_on, cleared by disp_off. If both are asserted on the same tick, disp_off wins.

Timing counters
- h counts 0..BYTES_PER_LINE-1 and wraps to 0.
- v increments when h wraps and itself wraps at LINES_PER_FRAME-1.
- frame_start pulses on the tick where (h, v) becomes (0, 0). line_repeat is latched on that same tick, so changes mid-frame have no effect until the next frame.

Output decodes (evaluated from the post-tick counter values)
- EF_n = 0 for v in [ACTIVE_START-EF_LINES, ACTIVE_START-1] and v in [ACTIVE_START+ACTIVE_LINES-EF_LINES, ACTIVE_START+ACTIVE_LINES-1]. EF_n is independent of enabled.
- INT_n = 0 when enabled and v in [ACTIVE_START-INT_LEAD, ACTIVE_START-1].
- DMAO_n = 0 when enabled, v is in the active window, and h in [DMA_START, DMA_START+DMA_BYTES-1].

DMA capture
- A DMA cycle is a tick with SC = 10, enabled = 1, and v in the active window.
- If byte_cnt < DMA_BYTES:
  - mem_addr = row_cnt*DMA_BYTES + byte_cnt, mem_data = data_in, mem_wr_en = 1 for one clk;
  - byte_cnt increments.
- If byte_cnt = DMA_BYTES: mem_wr_en stays 0 and dma_overrun pulses.
- SC = 10 outside the active window, or while disabled, is ignored silently (no write, no overrun).

Line/row tracking
- byte_cnt clears at every line wrap.
- row_cnt and rep_cnt clear at v = ACTIVE_START.
- At the wrap of each active line, rep_cnt increments. When rep_cnt reaches 2^repeat - 1 it clears and row_cnt increments.
- Repeated lines therefore rewrite the same row; the last write wins.
- row_cnt never exceeds ACTIVE_LINES>>repeat - 1, so the address range is never exceeded.

Other rules
- disp_off mid-line: DMAO_n goes high on the next tick. DMA cycles already issued by the CPU in that tick are still captured only if enabled was 1 at the tick.

Decomposition:
- Package pixie_pkg holds:
  - SC encodings SC_FETCH/SC_EXECUTE/SC_DMA/SC_INT;
  - line_repeat encodings REP_1/REP_2/REP_4/REP_8;
  - a function computing row count for a given repeat.
- Natural sub-module: pixie_timing_gen. It contains the h/v counters, frame_start, and window decodes (active, int_win, ef_win, dma_slot).
- The top level holds the enable flag, DMA capture, and address generation.

Test Plan:
- Reset, disp_on, repeat 0, SC = 10 on every DMAO_n-low tick:
  - INT_n low for lines 78-79 only; EF_n low for lines 76-79 and 204-207;
  - DMAO_n low at h = 1..8 on lines 80..207;
  - line 80 writes addr 0..7, line 207 writes addr 1016..1023;
  - frame_start pulses once per 262*14 ticks.
- line_repeat = 1 latched at frame start → lines 80 and 81 both write addr 0..7; line 82 writes 8..15; line 207 writes 504..511.
- Nine SC = 10 ticks in one active line → eight writes (addr n..n+7); the 9th has mem_wr_en = 0 and dma_overrun = 1 for one clk.
- disp_off at line 100, h = 4 → DMAO_n high from the next tick, no further writes, INT_n stays high next frame, EF_n unchanged. disp_on together with disp_off → stays disabled.
- line_repeat changed mid-frame, from 0 to 2 at line 120 → addressing follows repeat 0 until the next frame_start, then line 80..83 all write addr 0..7.
- reset_n pulsed low at line 150, h = 5, for 3 clk → all outputs return to reset values asynchronously; after release, the first frame_start occurs 262*14 ticks later and the first write goes to addr 0.
